// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master split-capable bus arbiter.
package bus_pkg;

    // Arbiter FSM state; encodings are visible on the debug port.
    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StM1   = 4'd1,
        StM2   = 4'd2
    } arb_state_t;

    // Master identifiers, also the bus_sel / split_master encoding.
    localparam logic MID_M1 = 1'b0;
    localparam logic MID_M2 = 1'b1;

endpackage

// File: rtl/split_tracker.sv
// Holds the single split slot: parked master, resume latch, timeout counter and abort pulse.
module split_tracker
    import bus_pkg::*;
#(
    parameter int unsigned SPLIT_TIMEOUT = 256,
    parameter int unsigned CNT_W         = 9
) (
    input  logic clk,
    input  logic rstn,
    input  logic split_set,      // owner was split this cycle (slot known to be free)
    input  logic split_id,       // which master was split
    input  logic regrant,        // parked master is being re-granted this cycle
    input  logic split_done,
    output logic split_pending,
    output logic split_master,
    output logic resume,
    output logic split_abort
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SPLIT_TIMEOUT - 1);

    logic             pending_q, pending_d;
    logic             master_q, master_d;
    logic             resume_q, resume_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state for the split slot; split_done beats a same-cycle timeout.
    always_comb begin
        pending_d = pending_q;
        master_d  = master_q;
        resume_d  = resume_q;
        cnt_d     = cnt_q;
        abort_d   = 1'b0;
        if (split_set) begin
            pending_d = 1'b1;
            master_d  = split_id;
            resume_d  = 1'b0;
            cnt_d     = '0;
        end else if (pending_q) begin
            if (regrant) begin
                pending_d = 1'b0;
                resume_d  = 1'b0;
                cnt_d     = '0;
            end else if (!resume_q) begin
                if (split_done) begin
                    resume_d = 1'b1;
                end else if (cnt_q == CntLast) begin
                    pending_d = 1'b0;
                    abort_d   = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Split slot registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= 1'b0;
            master_q  <= MID_M1;
            resume_q  <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            master_q  <= master_d;
            resume_q  <= resume_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
        end
    end

    assign split_pending = pending_q;
    assign split_master  = master_q;
    assign resume        = resume_q;
    assign split_abort   = abort_q;

endmodule

// File: rtl/bus_arbiter_split.sv
// Two-master bus arbiter with registered grants and a single parked split transaction.
module bus_arbiter_split
    import bus_pkg::*;
#(
    parameter int unsigned SPLIT_TIMEOUT = 256,
    parameter int unsigned CNT_W         = 9
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       s_split,
    input  logic       split_done,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       bus_sel,
    output logic       split_pending,
    output logic       split_master,
    output logic       split_abort,
    output logic [3:0] arbiter_state
);

    arb_state_t state_q, state_d;
    logic       m1_grant_q, m1_grant_d;
    logic       m2_grant_q, m2_grant_d;
    logic       bus_sel_q, bus_sel_d;

    logic split_set, split_id, regrant, resume;
    logic m1_parked, m2_parked, parked_req;

    // A parked master stays locked out until the slave has reported ready.
    assign m1_parked  = split_pending && !resume && (split_master == MID_M1);
    assign m2_parked  = split_pending && !resume && (split_master == MID_M2);
    assign parked_req = (split_master == MID_M2) ? m2_req : m1_req;

    // Grant decision and owner tracking.
    always_comb begin
        state_d    = state_q;
        m1_grant_d = 1'b0;
        m2_grant_d = 1'b0;
        bus_sel_d  = bus_sel_q;
        split_set  = 1'b0;
        split_id   = MID_M1;
        regrant    = 1'b0;
        case (state_q)
            StIdle: begin
                if (split_pending && resume && parked_req) begin
                    regrant = 1'b1;
                    if (split_master == MID_M2) begin
                        state_d    = StM2;
                        m2_grant_d = 1'b1;
                        bus_sel_d  = MID_M2;
                    end else begin
                        state_d    = StM1;
                        m1_grant_d = 1'b1;
                        bus_sel_d  = MID_M1;
                    end
                end else if (m1_req && !m1_parked) begin
                    state_d    = StM1;
                    m1_grant_d = 1'b1;
                    bus_sel_d  = MID_M1;
                end else if (m2_req && !m2_parked) begin
                    state_d    = StM2;
                    m2_grant_d = 1'b1;
                    bus_sel_d  = MID_M2;
                end
            end
            StM1: begin
                if (s_split && !split_pending) begin
                    split_set = 1'b1;
                    split_id  = MID_M1;
                    state_d   = StIdle;
                end else if (!m1_req) begin
                    state_d = StIdle;
                end else begin
                    m1_grant_d = 1'b1;
                end
            end
            StM2: begin
                if (s_split && !split_pending) begin
                    split_set = 1'b1;
                    split_id  = MID_M2;
                    state_d   = StIdle;
                end else if (!m2_req) begin
                    state_d = StIdle;
                end else begin
                    m2_grant_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and registered grant outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            m1_grant_q <= 1'b0;
            m2_grant_q <= 1'b0;
            bus_sel_q  <= MID_M1;
        end else begin
            state_q    <= state_d;
            m1_grant_q <= m1_grant_d;
            m2_grant_q <= m2_grant_d;
            bus_sel_q  <= bus_sel_d;
        end
    end

    split_tracker #(
        .SPLIT_TIMEOUT(SPLIT_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_split_tracker (
        .clk          (clk),
        .rstn         (rstn),
        .split_set    (split_set),
        .split_id     (split_id),
        .regrant      (regrant),
        .split_done   (split_done),
        .split_pending(split_pending),
        .split_master (split_master),
        .resume       (resume),
        .split_abort  (split_abort)
    );

    assign m1_grant      = m1_grant_q;
    assign m2_grant      = m2_grant_q;
    assign bus_sel       = bus_sel_q;
    assign arbiter_state = state_q;

endmodule

// File: doc/bus_arbiter_split.md
# bus_arbiter_split

Two-master arbiter for the serial bus, with split-transaction support for a slow slave. It grants bus ownership to master 1 or master 2, drives the bus-select line that steers the master-side address, data and control mux, and parks a master whose slave signals split. That parked master is re-granted with top priority once the slave reports ready, or is released with an abort after a programmable timeout. It sits between the two master ports and the address decoder, replacing the fixed-owner path for the m2/s3 bus configuration.

## Interface
Parameters:
- SPLIT_TIMEOUT, default 256: cycles the arbiter waits for `split_done` before aborting a split.
- CNT_W, default 9: width of the split timeout counter; must satisfy 2^CNT_W > SPLIT_TIMEOUT.

Ports:
- clk  in  1  bus clock; all state changes on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- m1_req  in  1  master 1 bus request; level, held for the whole transaction.
- m2_req  in  1  master 2 bus request; level, held for the whole transaction.
- s_split  in  1  from the addressed slave, single-cycle pulse: split the current transaction.
- split_done  in  1  from the split slave, single-cycle pulse: slave ready to resume.
- m1_grant  out  1  master 1 owns the bus.
- m2_grant  out  1  master 2 owns the bus.
- bus_sel  out  1  mux select: 0 = master 1, 1 = master 2; holds its last value when idle.
- split_pending  out  1  a master is parked on a split.
- split_master  out  1  parked master: 0 = m1, 1 = m2; valid only while `split_pending` is 1.
- split_abort  out  1  one-cycle pulse when the split timeout expires.
- arbiter_state  out  4  current FSM state, for debug.

## Operation
- FSM states, with `arbiter_state` encodings: IDLE = 4'd0, M1 = 4'd1, M2 = 4'd2. All other encodings return to IDLE.
- IDLE: the grant decision uses this priority, highest first:
  - the split master, if `split_pending` is 1 and `split_done` has been latched, and that master is requesting;
  - m1, if `m1_req` is 1 and m1 is not parked;
  - m2, if `m2_req` is 1 and m2 is not parked.
- M1 and M2: the owner keeps the bus while its req is 1 and `s_split` is 0.
  - Req deasserted → IDLE.
  - `s_split` asserted → IDLE, `split_pending` = 1, `split_master` = the owner, timeout counter cleared.
- Parked master: its req is ignored until `split_done` is latched, even though the master keeps req high.
- `split_done` latch:
  - a pulse while `split_pending` is 1 sets an internal `resume` flag;
  - the flag clears when the parked master is re-granted, which also clears `split_pending`;
  - `split_done` while `split_pending` is 0 is ignored.
- Split while one split is already pending: ignored. Owner is kept; the single pending slot is not overwritten.
- Timeout: the counter increments every cycle while `split_pending` is 1 and `resume` is 0.
  - When it reaches SPLIT_TIMEOUT−1: `split_pending` clears, `split_abort` pulses for 1 cycle, and the counter resets.
  - The parked master then competes normally.
- Same cycle as timeout expiry: `split_done` wins and no abort is issued.
- Grants are one-hot or zero; m1_grant and m2_grant are never both 1.
- Reset values: state IDLE; m1_grant, m2_grant, bus_sel, split_pending, split_master, split_abort, resume and the counter all 0.
- Reset asserted mid-transaction or mid-split: all of the above clear immediately (asynchronous). After reset release the FSM starts in IDLE.

## Timing
- Grants and bus_sel are registered, with no combinational path from any input to any output.
- Request to grant: req sampled high in IDLE at edge N → grant high after edge N.
- Release: req sampled low at edge N → grant low after edge N, state IDLE. The next grant appears no earlier than after edge N+1, giving one idle turnaround cycle.
- Split: `s_split` sampled at edge N → grant low and `split_pending` high after edge N. The other master may be granted after edge N+1.
- Resume: `split_done` sampled at edge N while the FSM is in IDLE → parked master re-granted after edge N+1. If the other master owns the bus, re-grant follows that owner's release plus one idle cycle.
- `bus_sel` updates in the same cycle as the grant it accompanies.

## Structure
- Shared package `bus_pkg`:
  - `arb_state_t`, a 4-bit enum with IDLE/M1/M2;
  - master ID constants `MID_M1` = 1'b0 and `MID_M2` = 1'b1.
- Sub-module `split_tracker`: holds split_pending, split_master, resume, the timeout counter and split_abort. The top level contains only the FSM and the grant registers.

## Test plan
- Reset, then m1_req high for 5 cycles → m1_grant rises 1 cycle after req; bus_sel = 0; arbiter_state 0→1→0; grant falls 1 cycle after req drops.
- m1_req and m2_req rise in the same cycle → m1 granted first. After m1 releases, one idle cycle, then m2_grant = 1 with bus_sel = 1.
- m1 owns the bus, s_split pulse, m2_req high → split_pending = 1 and split_master = 0, m2 granted 1 cycle after m1's grant falls. split_done arrives during m2 ownership; m2 releases → m1 re-granted after one idle cycle, split_pending = 0.
- Split with no split_done, SPLIT_TIMEOUT = 8 → split_abort pulses exactly once, 8 cycles after the split; split_pending = 0; m1 (req still high) is granted next.
- split_done and timeout expiry in the same cycle → no abort; the parked master is re-granted.
- rstn pulsed low for 1 ns while split_pending = 1 and m2 owns the bus → all outputs 0 immediately, arbiter_state = 0, no abort after release.
